// File: rtl/muldiv_wb_scheduler_pkg.sv
// rtl/muldiv_wb_scheduler_pkg.sv - shared encodings for the multdiv writeback scheduler
package muldiv_wb_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  // Exception codes land in $r30; 1-3 belong to the ALU overflow path.
  localparam logic [4:0]  EXC_REG_NUM       = 5'd30;
  localparam logic [31:0] EXC_CODE_ADD_OVF  = 32'd1;
  localparam logic [31:0] EXC_CODE_ADDI_OVF = 32'd2;
  localparam logic [31:0] EXC_CODE_SUB_OVF  = 32'd3;
  localparam logic [31:0] EXC_CODE_MULT     = 32'd4;
  localparam logic [31:0] EXC_CODE_DIV      = 32'd5;

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/muldiv_wb_scheduler_if.sv
// rtl/muldiv_wb_scheduler_if.sv - X-stage, multdiv and regfile write signals of the scheduler
interface muldiv_wb_scheduler_if;
  logic        start_mult;
  logic        start_div;
  logic [4:0]  dest_reg;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        w_we;
  logic [4:0]  w_reg;
  logic [31:0] w_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall;
  logic        busy;
  logic        timeout_err;

  modport master (
    output start_mult, start_div, dest_reg, md_ready, md_exception, md_result,
           w_we, w_reg, w_data,
    input  md_ctrl_mult, md_ctrl_div, ctrl_writeEnable, ctrl_writeReg,
           data_writeReg, stall, busy, timeout_err
  );

  modport slave (
    input  start_mult, start_div, dest_reg, md_ready, md_exception, md_result,
           w_we, w_reg, w_data,
    output md_ctrl_mult, md_ctrl_div, ctrl_writeEnable, ctrl_writeReg,
           data_writeReg, stall, busy, timeout_err
  );
endinterface

// File: rtl/muldiv_wb_scheduler_wb_hold_buffer.sv
// rtl/muldiv_wb_scheduler_wb_hold_buffer.sv - one-entry buffer for a writeback displaced by the W stage
module muldiv_wb_scheduler_wb_hold_buffer
  import muldiv_wb_scheduler_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    capture_i,
  input  logic    drain_i,
  input  wb_req_t req_i,
  output logic    valid_o,
  output wb_req_t req_o
);

  logic    valid_q;
  logic    valid_d;
  wb_req_t req_q;
  wb_req_t req_d;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (capture_i) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/muldiv_wb_scheduler.sv
// rtl/muldiv_wb_scheduler.sv - multdiv sequencing and regfile write-port arbitration against the W stage
module muldiv_wb_scheduler
  import muldiv_wb_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [4:0]  EXC_REG  = EXC_REG_NUM,
  parameter logic [31:0] MULT_EXC = EXC_CODE_MULT,
  parameter logic [31:0] DIV_EXC  = EXC_CODE_DIV
)(
  input  logic                  clock,
  input  logic                  reset,
  muldiv_wb_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [4:0]       dest_q, dest_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  logic    start_any;
  logic    md_mult, md_div;
  logic    sched_we;
  wb_req_t sched_req;
  wb_req_t ret_req;
  logic    ret_suppress;
  logic    capture, drain;
  logic    hold_valid;
  wb_req_t hold_req;

  muldiv_wb_scheduler_wb_hold_buffer u_hold (
    .clock     (clock),
    .reset     (reset),
    .capture_i (capture),
    .drain_i   (drain),
    .req_i     (ret_req),
    .valid_o   (hold_valid),
    .req_o     (hold_req)
  );

  always_comb begin
    start_any    = bus.start_mult | bus.start_div;
    state_d      = state_q;
    op_d         = op_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    terr_d       = terr_q;
    md_mult      = 1'b0;
    md_div       = 1'b0;
    sched_we     = 1'b0;
    sched_req    = '0;
    capture      = 1'b0;
    drain        = 1'b0;
    ret_req.wreg  = bus.md_exception ? EXC_REG : dest_q;
    ret_req.wdata = bus.md_exception ? ((op_q == OP_MUL) ? MULT_EXC : DIV_EXC)
                                     : bus.md_result;
    // A clean result for r0 retires without a write, so it never needs the buffer.
    ret_suppress = !bus.md_exception && (dest_q == 5'd0);

    case (state_q)
      ST_IDLE: begin
        if (start_any) begin
          md_mult = bus.start_mult;
          md_div  = bus.start_div & ~bus.start_mult;
          op_d    = bus.start_mult ? OP_MUL : OP_DIV;
          dest_d  = bus.dest_reg;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.md_ready) begin
          if (ret_suppress) begin
            state_d = ST_IDLE;
          end else if (!bus.w_we) begin
            sched_we  = 1'b1;
            sched_req = ret_req;
            state_d   = ST_IDLE;
          end else begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!bus.w_we && hold_valid) begin
          sched_we  = 1'b1;
          sched_req = hold_req;
          drain     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      dest_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // W stage owns the port except in the cycle the scheduler retires.
  assign bus.ctrl_writeEnable = sched_we | bus.w_we;
  assign bus.ctrl_writeReg    = sched_we ? sched_req.wreg  : bus.w_reg;
  assign bus.data_writeReg    = sched_we ? sched_req.wdata : bus.w_data;
  assign bus.md_ctrl_mult     = md_mult;
  assign bus.md_ctrl_div      = md_div;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.stall            = (state_q != ST_IDLE) | start_any;
  assign bus.timeout_err      = terr_q;

endmodule

// File: tb/tb_muldiv_wb_scheduler.sv
// tb/tb_muldiv_wb_scheduler.sv - directed vector bench for muldiv_wb_scheduler
module tb_muldiv_wb_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  muldiv_wb_scheduler_if bus ();

  muldiv_wb_scheduler #(.TIMEOUT(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sm;
    logic        sd;
    logic [4:0]  dr;
    logic        rdy;
    logic        exc;
    logic [31:0] res;
    logic        wwe;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [42:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [42:0] ex(input logic mm, input logic md, input logic we,
                                     input logic [4:0] rg, input logic [31:0] dt,
                                     input logic st, input logic bz, input logic te);
    return {mm, md, we, rg, dt, st, bz, te};
  endfunction

  function automatic vec_t mk(input logic sm, input logic sd, input logic [4:0] dr,
                              input logic rdy, input logic exc, input logic [31:0] res,
                              input logic wwe, input logic [4:0] wr, input logic [31:0] wd,
                              input logic [42:0] e);
    vec_t v;
    v.sm = sm; v.sd = sd; v.dr = dr; v.rdy = rdy; v.exc = exc; v.res = res;
    v.wwe = wwe; v.wr = wr; v.wd = wd; v.exp = e;
    return v;
  endfunction

  function automatic logic [42:0] outs();
    return {bus.md_ctrl_mult, bus.md_ctrl_div, bus.ctrl_writeEnable, bus.ctrl_writeReg,
            bus.data_writeReg, bus.stall, bus.busy, bus.timeout_err};
  endfunction

  task automatic set_in(input logic sm, input logic sd, input logic [4:0] dr,
                        input logic rdy, input logic exc, input logic [31:0] res,
                        input logic wwe, input logic [4:0] wr, input logic [31:0] wd);
    bus.start_mult = sm; bus.start_div = sd; bus.dest_reg = dr;
    bus.md_ready = rdy; bus.md_exception = exc; bus.md_result = res;
    bus.w_we = wwe; bus.w_reg = wr; bus.w_data = wd;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [42:0] e);
    logic [42:0] act;
    act = outs();
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got {mm,md,we,reg,data,stall,busy,terr}=%h required %h", name, act, e);
    end
  endtask

  localparam logic [42:0] ZERO = 43'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Cycle-by-cycle vectors, applied back to back from the reset state.
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b1,5'd5,32'h1234,   ex(1'b0,1'b0,1'b1,5'd5,32'h1234,1'b0,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b0,32'hDEAD, 1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b1,1'b0,5'd7, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b0,32'h30,   1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b1,5'd7,32'h30,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b0,1'b1,5'd3, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b0,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b0,32'h11,   1'b1,5'd9,32'hAA,     ex(1'b0,1'b0,1'b1,5'd9,32'hAA,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b1,5'd10,32'hBB,    ex(1'b0,1'b0,1'b1,5'd10,32'hBB,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b0,32'h99,   1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b1,5'd3,32'h11,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b0,1'b1,5'd4, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b0,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b1,32'h77,   1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b1,5'd30,32'h5,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b1,1'b0,5'd8, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b1,32'h0,    1'b1,5'd2,32'h22,     ex(1'b0,1'b0,1'b1,5'd2,32'h22,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b1,5'd30,32'h4,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b1,1'b1,5'd12,1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b1,5'd13,1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b0,32'h5555, 1'b0,5'd0,32'h0,      ex(1'b0,1'b0,1'b1,5'd12,32'h5555,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));
    vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,1'b0,32'hFFFF, 1'b1,5'd6,32'h66,     ex(1'b0,1'b0,1'b1,5'd6,32'h66,1'b1,1'b1,1'b0)));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    1'b0,5'd0,32'h0,      ZERO));

    idle_in();
    repeat (2) @(negedge clock);
    chk("in_reset", ZERO);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      set_in(vecs[i].sm, vecs[i].sd, vecs[i].dr, vecs[i].rdy, vecs[i].exc, vecs[i].res,
             vecs[i].wwe, vecs[i].wr, vecs[i].wd);
      #2;
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Mult retiring 17 cycles after its start pulse.
    @(negedge clock);
    set_in(1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 chk("lat_start", ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0));
    for (int k = 1; k < 17; k++) begin
      @(negedge clock); idle_in();
      #2 chk($sformatf("lat_run%0d", k), ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0));
    end
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h30, 1'b0, 5'd0, 32'h0);
    #2 chk("lat_retire", ex(1'b0,1'b0,1'b1,5'd7,32'h30,1'b1,1'b1,1'b0));
    @(negedge clock); idle_in();
    #2 chk("lat_after", ZERO);

    // Timeout: no md_ready for 64 cycles.
    @(negedge clock);
    set_in(1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 chk("to_start", ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0));
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock); idle_in();
      #2 chk($sformatf("to_run%0d", k), ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0));
    end
    @(negedge clock); idle_in();
    #2 chk("to_expired", ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0,1'b1));
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h1, 1'b0, 5'd0, 32'h0);
    #2 chk("to_late_ready", ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0,1'b1));

    // Reset while in RUN.
    @(negedge clock);
    set_in(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 chk("rr_start", ex(1'b0,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b1));
    @(negedge clock); idle_in();
    #2 chk("rr_run", ex(1'b0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b1));
    reset = 1'b1;
    #1 chk("rr_async", ZERO);
    @(negedge clock); reset = 1'b0; idle_in();
    #2 chk("rr_released", ZERO);
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h44, 1'b0, 5'd0, 32'h0);
    #2 chk("rr_late_ready", ZERO);

    // Reset while in HOLD.
    @(negedge clock);
    set_in(1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 chk("rh_start", ex(1'b1,1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0));
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h55, 1'b1, 5'd1, 32'h10);
    #2 chk("rh_conflict", ex(1'b0,1'b0,1'b1,5'd1,32'h10,1'b1,1'b1,1'b0));
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd2, 32'h20);
    #2 chk("rh_hold", ex(1'b0,1'b0,1'b1,5'd2,32'h20,1'b1,1'b1,1'b0));
    reset = 1'b1;
    #1 chk("rh_async", ex(1'b0,1'b0,1'b1,5'd2,32'h20,1'b0,1'b0,1'b0));
    @(negedge clock); reset = 1'b0; idle_in();
    #2 chk("rh_released", ZERO);
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h66, 1'b0, 5'd0, 32'h0);
    #2 chk("rh_late_ready", ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_wb_scheduler.md
Name: muldiv_wb_scheduler

Overview:
- Sequences the multi-cycle multiplier/divider and arbitrates the single regfile write port between the MW stage and multdiv completions.
- Issues the start pulse and holds the pipeline stall while an operation is in flight.
- Retires the result, or the exception code to $r30, without colliding with a W-stage write.
- Sits between the X stage, the multdiv unit and the regfile write interface.

Parameters:
- TIMEOUT, 64, maximum cycles in RUN before the operation is abandoned.
- EXC_REG, 30, register written with the exception code.
- MULT_EXC, 4, code written on multiply exception.
- DIV_EXC, 5, code written on divide exception.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_mult  in  1  X-stage decode: mult in X this cycle.
- start_div  in  1  X-stage decode: div in X this cycle.
- dest_reg  in  5  rd of the X-stage mult/div.
- md_ctrl_mult  out  1  start pulse to multdiv.
- md_ctrl_div  out  1  start pulse to multdiv.
- md_ready  in  1  multdiv result valid (single-cycle pulse).
- md_exception  in  1  multdiv exception, qualified by md_ready.
- md_result  in  32  multdiv product/quotient.
- w_we  in  1  MW-stage regfile write enable.
- w_reg  in  5  MW-stage destination.
- w_data  in  32  MW-stage write data.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write register.
- data_writeReg  out  32  regfile write data.
- stall  out  1  freeze PC/FD/DX.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set when TIMEOUT expires.

Behaviour:
- Reset (async, active-high): state IDLE; op, dest, hold buffer and counter cleared; timeout_err=0. Combinational outputs therefore read md_ctrl_*=0, stall=0, busy=0, and the write port passes w_*.
- States: IDLE, RUN, HOLD.
- IDLE:
  - If start_mult or start_div: assert md_ctrl_* combinationally in the same cycle, so operands are still in X. Latch op and dest_reg, clear counter, go RUN.
  - If both starts are asserted, mult wins and only md_ctrl_mult pulses.
- RUN:
  - counter += 1 per cycle. start_* are ignored.
  - On md_ready, compute the write value:
    - md_exception=1: (EXC_REG, MULT_EXC or DIV_EXC per latched op).
    - Otherwise: (dest, md_result).
  - If w_we=0: drive ctrl_writeEnable=1 with that value this cycle, go IDLE.
  - If w_we=1: W stage keeps the port (W has priority). Capture the value into the hold buffer, go HOLD.
  - If counter == TIMEOUT-1 without md_ready: set timeout_err, go IDLE, no write.
- HOLD:
  - Drive the buffered write in the first cycle w_we=0, then go IDLE.
  - A md_ready arriving in HOLD is ignored.
- Write to register 0 with no exception: suppress ctrl_writeEnable and retire normally, with no HOLD needed.
- Write-port mux: scheduler write when retiring; otherwise ctrl_writeEnable/ctrl_writeReg/data_writeReg = w_we/w_reg/w_data.
- stall = (IDLE & (start_mult|start_div)) | RUN | HOLD. Stall remains 1 in the retire cycle and drops the cycle after.
- Latency: a multdiv that is ready N cycles after the start pulse retires in cycle N (no conflict). Each conflicting W-stage write adds 1 cycle.
- md_ready while IDLE is ignored.
- timeout_err is cleared only by reset.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, RUN=1, HOLD=2);
  - op encoding (MUL=0, DIV=1);
  - EXC_REG and the exception codes, shared with the ALU-overflow exception logic (codes 1–3).
- Natural sub-module: wb_hold_buffer, a 1-entry valid/reg/data register with capture and drain strobes.
- The FSM, counter and mux stay in the top.

Test Plan:
- Basic mult: start_mult=1, dest=7 → md_ctrl_mult pulses the same cycle, stall=1. md_ready 17 cycles later with result 0x0000_0030 and w_we=0 → write r7=0x30 in that cycle, stall=0 the next cycle.
- Write-port conflict: div, dest=3; md_ready with w_we=1 (w_reg=9, w_data=0xAA) → port writes r9=0xAA. Next cycle w_we=0 → r3 written from the hold buffer; stall spans one extra cycle.
- Exception: div, dest=4, md_ready with md_exception=1 → r30=5, r4 untouched. Same with mult → r30=4.
- Simultaneous/ignored starts: start_mult and start_div together → only md_ctrl_mult pulses. start_div while RUN → no pulse, dest unchanged.
- Timeout: start_mult, md_ready never asserted → after 64 cycles timeout_err=1, state IDLE, stall=0, no regfile write.
- Reset mid-operation: reset asserted in RUN and in HOLD → outputs return to reset values immediately (async). A later md_ready causes no write.
